// File: rtl/seq_mag_comparator_pkg.sv
// Shared types and constants for the sequential magnitude comparator.
package comp_pkg;

  // Controller states: waiting for a request, or walking slices MSB first.
  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_e;

  // Result encoding offered to consumers that prefer a packed code over flags.
  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  // Number of DIGIT-wide slices in a WIDTH-wide operand.
  function automatic int slice_count(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/seq_mag_comparator_if.sv
// Request/result bundle for the sequential magnitude comparator.
//
// Handshake: the requester raises start with a/b valid; the request is taken
// on a rising edge where busy=0 (start is the valid, !busy is the ready).
// a/b are sampled only on that edge. done pulses for one cycle when the result
// is ready; eq/gt/lt then hold until the next accepted start clears them.
interface seq_mag_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             eq;
  logic             gt;
  logic             lt;

  modport master (output start, a, b, input busy, done, eq, gt, lt);
  modport slave  (input start, a, b, output busy, done, eq, gt, lt);
endinterface

// File: rtl/seq_mag_comparator_slice_cmp.sv
// Unsigned compare of one DIGIT-wide slice pair; purely combinational.
module slice_cmp #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             s_eq,
  output logic             s_gt
);
  assign s_eq = (x == y);
  assign s_gt = (x > y);
endmodule

// File: rtl/seq_mag_comparator.sv
// Multi-cycle magnitude comparator: walks the operands DIGIT bits per cycle
// from the MSB slice down and stops at the first slice that differs.
module seq_mag_comparator
  import comp_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGIT  = 2,
  parameter int SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_mag_comparator_if.slave  bus,
  output state_e               state_o
);

  localparam int N     = slice_count(WIDTH, DIGIT);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  // Flipping both sign bits maps two's-complement order onto unsigned order.
  localparam logic [WIDTH-1:0] SIGN_MASK =
    (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("seq_mag_comparator: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] ra_q;
  logic [WIDTH-1:0] rb_q;
  logic [IDX_W-1:0] idx_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  logic [DIGIT-1:0] slice_a_d;
  logic [DIGIT-1:0] slice_b_d;
  logic             s_eq;
  logic             s_gt;

  // Pick the slice currently under inspection.
  always_comb begin
    slice_a_d = ra_q[idx_q * DIGIT +: DIGIT];
    slice_b_d = rb_q[idx_q * DIGIT +: DIGIT];
  end

  slice_cmp #(.DIGIT(DIGIT)) u_slice_cmp (
    .x    (slice_a_d),
    .y    (slice_b_d),
    .s_eq (s_eq),
    .s_gt (s_gt)
  );

  // Controller: accept a request in IDLE, then decide one slice per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            ra_q    <= bus.a ^ SIGN_MASK;
            rb_q    <= bus.b ^ SIGN_MASK;
            idx_q   <= IDX_W'(N - 1);
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            state_q <= CMP;
          end
        end
        CMP: begin
          if (!s_eq) begin
            gt_q    <= s_gt;
            lt_q    <= !s_gt;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == CMP);
  assign bus.done = done_q;
  assign bus.eq   = eq_q;
  assign bus.gt   = gt_q;
  assign bus.lt   = lt_q;
  assign state_o  = state_q;

endmodule
